// File: rtl/boot_loader_if.sv
// Host word-stream channel into the boot loader.
//   s_valid / s_ready : handshake, a word moves when both are high on a clk edge
//   s_data            : 32-bit program word
//   s_last            : final word of the image, meaningful only with s_valid
// master = host side, slave = loader side.
interface boot_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/boot_loader.sv
// Boot loader: streams a program image from the host into the core's unified
// memory while holding the core in reset, then releases the core.
//   clk, reset    : clock, asynchronous active-high reset
//   start         : one-cycle pulse, begins a load from IDLE or RUN
//   host          : word stream (s_valid/s_ready/s_data/s_last)
//   mem_we/addr/wdata : memory write port, one registered pulse per accepted word
//   core_reset    : held high except in RUN
//   busy / done   : in LOAD or HOLD / in RUN
//   overflow      : sticky, image ran into the end of memory without s_last
//   word_count    : words written in the current or last load
module boot_loader #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RESET_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  boot_loader_if.slave    host,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            core_reset,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [ADDR_W:0] word_count
);
  localparam int              HW        = $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [HW-1:0]   HOLD_INIT = HW'(RESET_HOLD);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t          state, state_nx;
  logic            accept;
  logic            mem_full;
  logic [ADDR_W:0] count_inc;
  logic [HW-1:0]   hold_cnt;

  assign accept    = host.s_valid & host.s_ready;
  assign count_inc = word_count + {{ADDR_W{1'b0}}, 1'b1};
  // This accept fills the last word of memory.
  assign mem_full  = (count_inc == DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    host.s_ready = 1'b0;
    core_reset   = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        host.s_ready = 1'b1;
        busy         = 1'b1;
        if (accept && (host.s_last || mem_full)) state_nx = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        // Counter steps to zero on this edge: core leaves reset.
        if (hold_cnt == HOLD_ONE) state_nx = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      // Write is the registered image of the accept: exactly one cycle later.
      mem_we <= accept;
      if (accept) begin
        mem_addr   <= BASE_ADDR + 32'({word_count[ADDR_W-1:0], 2'b00});
        mem_wdata  <= host.s_data;
        word_count <= count_inc;
        if (mem_full && !host.s_last) overflow <= 1'b1;
      end
      if (start && (state == IDLE || state == RUN)) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (state == LOAD && state_nx == HOLD) hold_cnt <= HOLD_INIT;
      else if (state == HOLD)                hold_cnt <= hold_cnt - HOLD_ONE;
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (1024-word at base 0, 4-word at base
// 0x100), selected by sel. A reference model derives, from the image alone,
// which words get written, where, when, and when the core is released.
module tb_boot_loader;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel = 1'b0, start = 1'b0, valid = 1'b0, last = 1'b0;
  logic [31:0] data = '0;

  boot_loader_if ifa();
  boot_loader_if ifb();
  assign ifa.s_valid = valid & ~sel;
  assign ifa.s_data  = data;
  assign ifa.s_last  = last;
  assign ifb.s_valid = valid & sel;
  assign ifb.s_data  = data;
  assign ifb.s_last  = last;

  logic        a_we, a_cr, a_busy, a_done, a_ovf;
  logic [31:0] a_addr, a_wdata;
  logic [10:0] a_wc;
  logic        b_we, b_cr, b_busy, b_done, b_ovf;
  logic [31:0] b_addr, b_wdata;
  logic [2:0]  b_wc;
  logic        start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  boot_loader #(.ADDR_W(10), .BASE_ADDR(32'h0), .RESET_HOLD(HOLD)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .host(ifa),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .core_reset(a_cr),
    .busy(a_busy), .done(a_done), .overflow(a_ovf), .word_count(a_wc));

  boot_loader #(.ADDR_W(2), .BASE_ADDR(32'h100), .RESET_HOLD(HOLD)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .host(ifb),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .core_reset(b_cr),
    .busy(b_busy), .done(b_done), .overflow(b_ovf), .word_count(b_wc));

  logic        o_we, o_cr, o_busy, o_done, o_ovf, o_ready;
  logic [31:0] o_addr, o_wdata;
  logic [10:0] o_wc;
  assign o_we    = sel ? b_we    : a_we;
  assign o_cr    = sel ? b_cr    : a_cr;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_ovf   = sel ? b_ovf   : a_ovf;
  assign o_ready = sel ? ifb.s_ready : ifa.s_ready;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_wc    = sel ? {8'b0, b_wc} : a_wc;

  int total = 0, bad = 0;

  // Observed memory writes.
  logic [31:0] w_addr[$], w_data[$];
  int          w_cyc[$];
  always @(negedge clk) if (o_we) begin
    w_addr.push_back(o_addr);
    w_data.push_back(o_wdata);
    w_cyc.push_back(cyc);
  end

  // Image to present: word, s_last flag, idle cycles before the word.
  logic [31:0] img[$];
  bit          lst[$];
  int          gap[$];

  task automatic clear_img();
    img.delete(); lst.delete(); gap.delete();
  endtask

  // Full load from IDLE or RUN. poke pulses start in LOAD and in HOLD.
  task automatic run_load(input bit poke);
    int          depth, n_acc, trel, t_acc[$];
    logic [31:0] base;
    bit          ovf_exp;
    depth = sel ? 4 : 1024;
    base  = sel ? 32'h100 : 32'h0;
    // Model: image ends at the first s_last word or when memory is full.
    n_acc = 0;
    foreach (img[k]) begin
      n_acc++;
      if (lst[k] || n_acc == depth) break;
    end
    ovf_exp = (n_acc == depth) && !lst[n_acc-1];

    w_addr.delete(); w_data.delete(); w_cyc.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++;
    if ({o_cr, o_busy, o_done, o_ovf} !== 4'b1100 || o_wc !== 11'd0) begin
      bad++;
      $display("FAIL load_entry got cr/busy/done/ovf=%b wc=%0d exp=1100 wc=0",
               {o_cr, o_busy, o_done, o_ovf}, o_wc);
    end

    foreach (img[k]) begin
      for (int g = 0; g < gap[k]; g++) begin
        valid = 1'b0; last = 1'b0;
        @(negedge clk);
      end
      valid = 1'b1; data = img[k]; last = lst[k];
      start = poke && (k == 1);
      #1;
      t_acc.push_back(cyc);
      total++;
      if (o_ready !== (k < n_acc)) begin
        bad++;
        $display("FAIL s_ready word %0d got=%b exp=%b", k, o_ready, (k < n_acc));
      end
      @(negedge clk);
      start = 1'b0;
    end
    valid = 1'b0; last = 1'b0;

    trel = -1;
    for (int i = 0; i < 40 && trel < 0; i++) begin
      if (!o_cr) trel = cyc;
      else begin
        start = poke && (i == 0);
        @(negedge clk);
        start = 1'b0;
      end
    end
    total++;
    if (trel != t_acc[n_acc-1] + HOLD + 1) begin
      bad++;
      $display("FAIL release_cycle got=%0d exp=%0d", trel, t_acc[n_acc-1] + HOLD + 1);
    end

    total++;
    if (w_addr.size() != n_acc) begin
      bad++;
      $display("FAIL write_count got=%0d exp=%0d", w_addr.size(), n_acc);
    end
    for (int k = 0; k < n_acc && k < w_addr.size(); k++) begin
      total++;
      if (w_addr[k] !== base + 32'(4 * k) || w_data[k] !== img[k] ||
          w_cyc[k] != t_acc[k] + 1) begin
        bad++;
        $display("FAIL write[%0d] got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                 k, w_addr[k], w_data[k], w_cyc[k], base + 32'(4 * k), img[k], t_acc[k] + 1);
      end
    end

    total++;
    if (o_wc !== 11'(n_acc) || o_ovf !== ovf_exp || o_done !== 1'b1 ||
        o_busy !== 1'b0 || o_ready !== 1'b0 || o_we !== 1'b0) begin
      bad++;
      $display("FAIL load_end got wc=%0d ovf=%b done=%b busy=%b rdy=%b we=%b exp wc=%0d ovf=%b done=1 busy=0 rdy=0 we=0",
               o_wc, o_ovf, o_done, o_busy, o_ready, o_we, n_acc, ovf_exp);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({a_cr, a_we, ifa.s_ready, a_busy, a_done, a_ovf} !== 6'b100000 ||
        a_wc !== 11'd0 || a_addr !== 32'd0 || a_wdata !== 32'd0 ||
        {b_cr, b_we, ifb.s_ready, b_busy, b_done, b_ovf} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_state got a=%b b=%b wc=%0d addr=%h wdata=%h exp 100000 zeros",
               {a_cr, a_we, ifa.s_ready, a_busy, a_done, a_ovf},
               {b_cr, b_we, ifb.s_ready, b_busy, b_done, b_ovf}, a_wc, a_addr, a_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({o_cr, o_ready, o_busy, o_done} !== 4'b1000) begin
      bad++;
      $display("FAIL idle_state got=%b exp=1000", {o_cr, o_ready, o_busy, o_done});
    end
  endtask

  task automatic test_basic();
    clear_img();
    img = '{32'h00500093, 32'h00100113, 32'h002081B3};
    lst = '{0, 0, 1};
    gap = '{0, 0, 0};
    run_load(1'b0);
  endtask

  task automatic test_stalls();
    clear_img();
    img = '{32'h00500093, 32'h00100113, 32'h002081B3};
    lst = '{0, 0, 1};
    gap = '{0, 2, 2};
    run_load(1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      clear_img();
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        img.push_back($urandom);
        lst.push_back(k == n - 1);
        gap.push_back(int'($urandom_range(0, 3)));
      end
      run_load(1'b0);
    end
  endtask

  task automatic test_start_ignored();
    clear_img();
    for (int k = 0; k < 4; k++) begin
      img.push_back($urandom);
      lst.push_back(k == 3);
      gap.push_back(k == 2 ? 1 : 0);
    end
    run_load(1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    valid = 1'b1; data = 32'hAAAA0001;
    @(negedge clk); data = 32'hAAAA0002;
    @(negedge clk); data = 32'hAAAA0003;
    total++;
    if (o_we !== 1'b1 || o_wc !== 11'd2) begin
      bad++;
      $display("FAIL pre_abort got we=%b wc=%0d exp we=1 wc=2", o_we, o_wc);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({o_cr, o_we, o_ready, o_busy, o_done} !== 5'b10000 || o_wc !== 11'd0) begin
      bad++;
      $display("FAIL abort got cr/we/rdy/busy/done=%b wc=%0d exp=10000 wc=0",
               {o_cr, o_we, o_ready, o_busy, o_done}, o_wc);
    end
    valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    clear_img();
    img = '{$urandom, $urandom};
    lst = '{0, 1};
    gap = '{0, 1};
    run_load(1'b0);
  endtask

  task automatic test_overflow();
    @(negedge clk); sel = 1'b1;
    clear_img();
    for (int k = 0; k < 6; k++) begin
      img.push_back($urandom);
      lst.push_back(1'b0);
      gap.push_back(0);
    end
    run_load(1'b0);
  endtask

  task automatic test_reload();
    clear_img();
    img = '{32'hDEADBEEF};
    lst = '{1};
    gap = '{0};
    run_load(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_overflow();
    test_reload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Loads a program image into the processor's unified instruction/data memory from a host word stream.
- Holds the multicycle core in reset during the load, then releases it so the control FSM's first FETCH starts from a fully loaded memory.
- Sits upstream of the core: it drives the core's reset and shares the memory write port while the core is held.

Parameters:
- ADDR_W, 10, word-address width; memory depth DEPTH = 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be word-aligned.
- RESET_HOLD, 4, cycles core_reset stays high after the last write before release; must be ≥1.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse that begins a load.
- s_valid, input, 1, host word valid.
- s_ready, output, 1, loader accepts a word this cycle.
- s_data, input, 32, program word.
- s_last, input, 1, marks the final word of the image; qualified by s_valid.
- mem_we, output, 1, memory write enable.
- mem_addr, output, 32, memory byte address.
- mem_wdata, output, 32, memory write data.
- core_reset, output, 1, active-high reset to the core (FSM, PC, registers).
- busy, output, 1, high in LOAD or HOLD.
- done, output, 1, high in RUN.
- overflow, output, 1, sticky flag: image exceeded DEPTH.
- word_count, output, ADDR_W+1, number of words written in the current or last load.

Behaviour:
- States are IDLE, LOAD, HOLD and RUN.
- Reset (asynchronous, immediate):
  - state = IDLE.
  - core_reset = 1.
  - s_ready, mem_we, busy, done, overflow = 0.
  - word_count, mem_addr, mem_wdata = 0.
  - Reset during LOAD or HOLD aborts the load immediately; no further writes are issued.
- IDLE:
  - core_reset = 1, s_ready = 0.
  - start → LOAD; clear word_count and overflow.
  - A start in the same cycle as s_valid does not accept that word.
- LOAD:
  - s_ready = 1 combinationally, in every LOAD cycle.
  - Accept = s_valid & s_ready.
  - On accept, the next cycle has:
    - mem_we = 1 for exactly one cycle;
    - mem_addr = BASE_ADDR + 4*word_count (pre-increment value);
    - mem_wdata = s_data.
  - word_count increments in that same edge.
  - Write latency is 1 cycle from accept.
  - Back-to-back accepts produce consecutive write pulses at consecutive word addresses.
  - s_valid low: no accept, no write, state held.
  - Accepted word with s_last = 1 → HOLD.
  - Accepted word that makes word_count == DEPTH with s_last = 0 → HOLD and set overflow. Any later host words are not accepted (s_ready = 0).
  - start is ignored in LOAD.
- HOLD:
  - s_ready = 0, core_reset = 1.
  - The hold counter loads RESET_HOLD on entry and decrements each cycle.
  - The final mem_we pulse occurs in the first HOLD cycle.
  - Counter reaching 0 → RUN; core_reset drops on the edge entering RUN.
  - Total core_reset-high cycles after the last-word accept = RESET_HOLD + 1.
  - start is ignored in HOLD.
- RUN:
  - core_reset = 0, done = 1, s_ready = 0, mem_we = 0.
  - word_count and overflow are held.
  - start → LOAD: core_reset reasserts on that edge, word_count and overflow clear, done drops.
- Arithmetic:
  - mem_addr is 32-bit, with upper bits from BASE_ADDR.
  - The word index is ADDR_W bits and never wraps, because the DEPTH limit forces HOLD first.
- mem_we is never high outside the cycle after an accept.
- busy = (state == LOAD) | (state == HOLD).

Test Plan:
- Basic load (BASE_ADDR = 0, RESET_HOLD = 4): reset, start, stream 3 words 0x00500093, 0x00100113, 0x002081B3 with s_last on the third → mem_we pulses at addresses 0x0, 0x4, 0x8 with matching data; word_count = 3; core_reset falls exactly 5 cycles after the third accept; done = 1; overflow = 0.
- Host stalls: same 3 words with s_valid low for 2 cycles between each → only 3 mem_we pulses, each one cycle after its accept; addresses still 0x0, 0x4, 0x8.
- Overflow (ADDR_W = 2): stream 6 words, never s_last → 4 writes at 0x0–0xC; overflow = 1; s_ready = 0 after the 4th accept; word_count = 4; core_reset released after hold.
- Reset mid-load: assert reset asynchronously after 2 accepts → core_reset = 1, mem_we = 0, s_ready = 0 within the same cycle; state IDLE; a later start reloads from word_count = 0.
- Reload from RUN (BASE_ADDR = 0x100): after a completed load, pulse start → core_reset = 1 on the next edge, done = 0, overflow cleared; a single word with s_last written to 0x100; word_count = 1.
- start ignored: pulse start during LOAD and during HOLD → no state change and word_count unaffected.
